// File: rtl/io_mailbox_pkg.sv
// Shared register map, status bit positions and bus FSM encoding for io_mailbox.
// Pure declarations: no latency and no backpressure of its own.
package io_mailbox_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXCNT  = 2'd2;
  localparam logic [1:0] REG_RXCNT  = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_RX_OVF   = 4;
  localparam int ST_RX_UNF   = 5;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_ACK    = 2'd1,
    BUS_WSTALL = 2'd2
  } bus_state_t;

  function automatic logic [7:0] pack_status(input logic tx_full, input logic tx_empty,
                                             input logic rx_empty, input logic rx_full,
                                             input logic rx_ovf, input logic rx_unf);
    logic [7:0] s;
    s = 8'h00;
    s[ST_TX_FULL]  = tx_full;
    s[ST_TX_EMPTY] = tx_empty;
    s[ST_RX_EMPTY] = rx_empty;
    s[ST_RX_FULL]  = rx_full;
    s[ST_RX_OVF]   = rx_ovf;
    s[ST_RX_UNF]   = rx_unf;
    return s;
  endfunction

endpackage

// File: rtl/io_mailbox_sync_fifo.sv
// Byte FIFO with combinational head (0x00 when empty); push lands and pop retires at the clock edge.
// Push is refused when full unless a pop retires in the same cycle; pop on empty is ignored.
module sync_fifo #(
  parameter int size_addr = 3,
  parameter int size      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [7:0]           din,
  output logic [7:0]           dout,
  output logic                 full,
  output logic                 empty,
  output logic [size_addr:0]   count
);

  localparam logic [size_addr:0] FULL_CNT = (size_addr + 1)'(size);

  logic [7:0]           mem_q [size];
  logic [size_addr-1:0] wr_ptr_q, wr_ptr_d;
  logic [size_addr-1:0] rd_ptr_q, rd_ptr_d;
  logic [size_addr:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/io_mailbox.sv
// CPU-bus mailbox: TX FIFO drained by valid/ack, RX FIFO filled by valid, status/count registers.
// Reads and writes ack one cycle after acceptance; DATA writes to a full TX stall until space frees.
module io_mailbox
  import io_mailbox_pkg::*;
#(
  parameter int size_addr = 3,
  parameter int size      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic       read,
  input  logic       write,
  input  logic [1:0] address,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       ready_r,
  output logic       ready_w,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ack,
  input  logic       rx_valid,
  input  logic [7:0] rx_data
);

  bus_state_t state_q, state_d;
  logic       rd_q, rd_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]           tx_dout;
  logic [size_addr:0]   tx_count;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]           rx_dout;
  logic [size_addr:0]   rx_count;

  logic       accept, acc_rd, acc_wr, tx_space, stall_done;
  logic [7:0] status;

  // IDLE is the only state without a strobe, so a held request can never be taken twice in a row.
  assign accept   = (state_q == BUS_IDLE) & sel & (read | write);
  assign acc_rd   = accept & read;
  assign acc_wr   = accept & ~read;
  assign tx_pop   = tx_ack & ~tx_empty;
  assign tx_space = ~tx_full | tx_pop;
  assign rx_push  = rx_valid & (~rx_full | rx_pop);
  assign status   = pack_status(tx_full, tx_empty, rx_empty, rx_full, ovf_q, unf_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BUS_IDLE;
      rd_q    <= 1'b0;
      rdata_q <= 8'h00;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BUS_IDLE: begin
        if (accept)
          state_d = (!read && address == REG_DATA && !tx_space) ? BUS_WSTALL : BUS_ACK;
      end
      BUS_ACK:    state_d = BUS_IDLE;
      BUS_WSTALL: if (!(sel && write) || tx_space) state_d = BUS_IDLE;
      default:    state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    rd_d       = rd_q;
    rdata_d    = 8'h00;
    tx_push    = 1'b0;
    rx_pop     = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    stall_done = 1'b0;

    if (acc_rd) begin
      rd_d = 1'b1;
      unique case (address)
        REG_DATA: begin
          if (rx_empty) begin
            unf_d = 1'b1;
          end else begin
            rx_pop  = 1'b1;
            rdata_d = rx_dout;
          end
        end
        REG_STATUS: rdata_d = status;
        REG_TXCNT:  rdata_d = 8'(tx_count);
        default:    rdata_d = 8'(rx_count);
      endcase
    end

    if (acc_wr) begin
      rd_d = 1'b0;
      if (address == REG_DATA && tx_space) tx_push = 1'b1;
      if (address == REG_STATUS) begin
        if (data_in[ST_RX_OVF]) ovf_d = 1'b0;
        if (data_in[ST_RX_UNF]) unf_d = 1'b0;
      end
    end

    if (state_q == BUS_WSTALL && sel && write && tx_space) begin
      stall_done = 1'b1;
      tx_push    = 1'b1;
    end

    // A fresh overflow outranks a same-cycle clear so no dropped byte goes unreported.
    if (rx_valid && rx_full && !rx_pop) ovf_d = 1'b1;
  end

  assign ready_r  = (state_q == BUS_ACK) & rd_q;
  assign ready_w  = ((state_q == BUS_ACK) & ~rd_q) | stall_done;
  assign data_out = rdata_q;
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_dout;

  sync_fifo #(.size_addr(size_addr), .size(size)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (data_in),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.size_addr(size_addr), .size(size)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

endmodule

// File: tb/tb_io_mailbox.sv
// Directed-vector bench for io_mailbox: bus handshake, FIFO ordering, stall, flags and reset.
module tb_io_mailbox;
  import io_mailbox_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0, read = 1'b0, write = 1'b0;
  logic [1:0] address = 2'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       ready_r, ready_w, tx_valid;
  logic [7:0] tx_data;
  logic       tx_ack = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] r;

  io_mailbox #(.size_addr(3), .size(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .read     (read),
    .write    (write),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .ready_r  (ready_r),
    .ready_w  (ready_w),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ack   (tx_ack),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    logic seen;
    seen = 1'b0;
    sel = 1'b1; write = 1'b1; address = a; data_in = d;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ready_w) seen = 1'b1;
    end
    check_vec("wr_done", {7'd0, seen}, 8'h01);
    @(posedge clk); #1;
    sel = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    logic seen;
    seen = 1'b0;
    d = 8'hxx;
    sel = 1'b1; read = 1'b1; address = a;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ready_r) begin
        seen = 1'b1;
        d = data_out;
      end
    end
    check_vec("rd_done", {7'd0, seen}, 8'h01);
    @(posedge clk); #1;
    sel = 1'b0; read = 1'b0;
  endtask

  task automatic tx_pop();
    tx_ack = 1'b1;
    @(posedge clk); #1;
    tx_ack = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic fill_tx(input logic [7:0] base);
    for (int i = 0; i < 8; i++) bus_write(REG_DATA, base + 8'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_vec("rst_ready_r",  {7'd0, ready_r},  8'h00);
    check_vec("rst_ready_w",  {7'd0, ready_w},  8'h00);
    check_vec("rst_data_out", data_out,         8'h00);
    check_vec("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    check_vec("rst_tx_data",  tx_data,          8'h00);
    @(posedge clk); #1;
    bus_read(REG_STATUS, r); check_vec("status_reset", r, 8'h06);
    bus_read(REG_TXCNT, r);  check_vec("txcnt_reset",  r, 8'h00);
    bus_read(REG_RXCNT, r);  check_vec("rxcnt_reset",  r, 8'h00);

    // TX basic ordering
    bus_write(REG_DATA, 8'hA5);
    bus_write(REG_DATA, 8'h3C);
    bus_read(REG_TXCNT, r); check_vec("txcnt_two", r, 8'h02);
    check_vec("tx_valid_two", {7'd0, tx_valid}, 8'h01);
    check_vec("tx_head_a5", tx_data, 8'hA5);
    tx_pop();
    check_vec("tx_head_3c", tx_data, 8'h3C);
    tx_pop();
    check_vec("tx_drained", {7'd0, tx_valid}, 8'h00);

    // TX full stall released by tx_ack
    fill_tx(8'h40);
    bus_read(REG_TXCNT, r);  check_vec("txcnt_full", r, 8'h08);
    bus_read(REG_STATUS, r); check_vec("status_txfull", r, 8'h05);
    sel = 1'b1; write = 1'b1; address = REG_DATA; data_in = 8'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_vec("stall_hold", {7'd0, ready_w}, 8'h00);
    end
    @(posedge clk); #1;
    tx_ack = 1'b1;
    @(negedge clk);
    check_vec("stall_release", {7'd0, ready_w}, 8'h01);
    @(posedge clk); #1;
    tx_ack = 1'b0; sel = 1'b0; write = 1'b0;
    @(negedge clk);
    check_vec("stall_single", {7'd0, ready_w}, 8'h00);
    @(posedge clk); #1;
    bus_read(REG_TXCNT, r); check_vec("txcnt_after_stall", r, 8'h08);
    for (int i = 0; i < 8; i++) begin
      check_vec("tx_order", tx_data, (i < 7) ? 8'h41 + 8'(i) : 8'h77);
      tx_pop();
    end
    check_vec("tx_empty_again", {7'd0, tx_valid}, 8'h00);

    // RX overflow, underflow and flag clear
    for (int i = 0; i < 9; i++) rx_push(8'h10 + 8'(i));
    bus_read(REG_STATUS, r); check_vec("status_ovf", r, 8'h1A);
    bus_read(REG_RXCNT, r);  check_vec("rxcnt_full", r, 8'h08);
    for (int i = 0; i < 8; i++) begin
      bus_read(REG_DATA, r); check_vec("rx_order", r, 8'h10 + 8'(i));
    end
    bus_read(REG_DATA, r);   check_vec("rx_underflow_data", r, 8'h00);
    bus_read(REG_STATUS, r); check_vec("status_unf", r, 8'h36);
    bus_write(REG_STATUS, 8'h30);
    bus_read(REG_STATUS, r); check_vec("status_cleared", r, 8'h06);

    // RX full: push and pop in the same cycle
    for (int i = 0; i < 8; i++) rx_push(8'h50 + 8'(i));
    sel = 1'b1; read = 1'b1; address = REG_DATA; rx_valid = 1'b1; rx_data = 8'h58;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check_vec("pushpop_rdy", {7'd0, ready_r}, 8'h01);
    check_vec("pushpop_data", data_out, 8'h50);
    @(posedge clk); #1;
    sel = 1'b0; read = 1'b0;
    bus_read(REG_STATUS, r); check_vec("status_pushpop", r, 8'h0A);
    for (int i = 0; i < 8; i++) begin
      bus_read(REG_DATA, r); check_vec("rx_order2", r, 8'h51 + 8'(i));
    end

    // Held read strobes every other cycle; sel low blocks it
    sel = 1'b1; read = 1'b1; address = REG_RXCNT;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check_vec("held_read", {7'd0, ready_r}, (i % 2 == 0) ? 8'h01 : 8'h00);
    end
    sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_vec("sel_low", {7'd0, ready_r}, 8'h00);
    end
    read = 1'b0;
    @(posedge clk); #1;

    // Reset during a TX-full stall
    fill_tx(8'h60);
    sel = 1'b1; write = 1'b1; address = REG_DATA; data_in = 8'h99;
    repeat (2) begin
      @(negedge clk);
      check_vec("stall_pre_reset", {7'd0, ready_w}, 8'h00);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; sel = 1'b0; write = 1'b0;
    @(negedge clk);
    check_vec("rst_stall_ready_w",  {7'd0, ready_w},  8'h00);
    check_vec("rst_stall_tx_valid", {7'd0, tx_valid}, 8'h00);
    check_vec("rst_stall_tx_data",  tx_data,          8'h00);
    check_vec("rst_stall_ready_r",  {7'd0, ready_r},  8'h00);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    bus_read(REG_TXCNT, r); check_vec("txcnt_post_reset", r, 8'h00);
    check_vec("tx_valid_post_reset", {7'd0, tx_valid}, 8'h00);

    // Request dropped mid-stall is abandoned
    fill_tx(8'h70);
    sel = 1'b1; write = 1'b1; address = REG_DATA; data_in = 8'hEE;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    sel = 1'b0; write = 1'b0;
    tx_pop();
    bus_read(REG_TXCNT, r); check_vec("txcnt_abandon", r, 8'h07);
    for (int i = 0; i < 7; i++) begin
      check_vec("tx_order3", tx_data, 8'h71 + 8'(i));
      tx_pop();
    end
    check_vec("tx_empty_abandon", {7'd0, tx_valid}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
